calc_operand_sequencer: RTL and testbench

- Upstream control stage of the calculator datapath. Collects two WIDTH-bit operands from switches using an enter button, then computes a sum or difference.
- Drives the result register's 5-bit data input and its load enable. Asserts the enable as a single-cycle strobe with data valid in the same cycle.
- Also exposes its state for status LEDs.

---
 rtl/calc_operand_sequencer.sv | 94 +++++++++
 tb/tb_calc_operand_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_operand_sequencer.sv
// Operand collection and add/subtract sequencer for the calculator datapath.
// Define CALC_CHAIN_EN to reuse the previous result as operand A after DONE.
module calc_operand_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             op_sub,
  input  logic             btn,
  output logic [WIDTH:0]   result_data,
  output logic             load_en,
  output logic [1:0]       state_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    GET_B   = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic             s1, s2, prev;
  logic [WIDTH-1:0] a, b;
  logic             sub_r;
  logic             press;

  // Rising edge of the synchronized button; one press per low-to-high transition.
  assign press     = s2 & ~prev;
  assign state_out = state;
  assign busy      = (state == GET_B) | (state == COMPUTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= GET_A;
      s1          <= 1'b0;
      s2          <= 1'b0;
      prev        <= 1'b0;
      a           <= '0;
      b           <= '0;
      sub_r       <= 1'b0;
      result_data <= '0;
      load_en     <= 1'b0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      prev    <= s2;
      load_en <= 1'b0;
      case (state)
        GET_A: begin
          if (press) begin
            a     <= sw;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (press) begin
            b     <= sw;
            sub_r <= op_sub;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          // Result width WIDTH+1 gives carry on add and two's-complement wrap on sub.
          if (sub_r)
            result_data <= {1'b0, a} - {1'b0, b};
          else
            result_data <= {1'b0, a} + {1'b0, b};
          load_en <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (press) begin
`ifdef CALC_CHAIN_EN
            a     <= result_data[WIDTH-1:0];
            b     <= '0;
            sub_r <= 1'b0;
            state <= GET_B;
`else
            a     <= '0;
            b     <= '0;
            sub_r <= 1'b0;
            state <= GET_A;
`endif
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed self-checking bench for calc_operand_sequencer (WIDTH=4).
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       op_sub;
  logic       btn;
  logic [4:0] result_data;
  logic       load_en;
  logic [1:0] state_out;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;
  logic [4:0] load_res = '0;

  calc_operand_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .sw(sw), .op_sub(op_sub), .btn(btn),
    .result_data(result_data), .load_en(load_en),
    .state_out(state_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every load strobe and the data presented with it.
  always @(negedge clk) begin
    if (load_en) begin
      load_cnt++;
      load_res = result_data;
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Button held 3 cycles (press acted on at the third edge), then released 3 cycles.
  task automatic press(input logic [3:0] val, input logic sub);
    sw     = val;
    op_sub = sub;
    btn    = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    reset  = 1'b1;
    sw     = '0;
    op_sub = 1'b0;
    btn    = 1'b0;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  sub: 1'b0, exp: 5'b01000};
    vecs[1] = '{a: 4'd15, b: 4'd15, sub: 1'b0, exp: 5'b11110};
    vecs[2] = '{a: 4'd0,  b: 4'd1,  sub: 1'b1, exp: 5'b11111};
    vecs[3] = '{a: 4'd7,  b: 4'd7,  sub: 1'b1, exp: 5'b00000};
    vecs[4] = '{a: 4'd9,  b: 4'd8,  sub: 1'b0, exp: 5'b10001};
    vecs[5] = '{a: 4'd2,  b: 4'd5,  sub: 1'b1, exp: 5'b11101};
    vecs[6] = '{a: 4'd10, b: 4'd3,  sub: 1'b1, exp: 5'b00111};
    vecs[7] = '{a: 4'd0,  b: 4'd0,  sub: 1'b0, exp: 5'b00000};

    // Reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_state", state_out, 0);
    check("idle_load", load_en, 0);
    check("idle_result", result_data, 0);
    check("idle_busy", busy, 0);
    check("idle_loadcnt", load_cnt, 0);

    // 3+5 with state/busy walk
    press(4'd3, 1'b0);
    check("seq_stateB", state_out, 1);
    check("seq_busyB", busy, 1);
    base = load_cnt;
    sw = 4'd5; op_sub = 1'b0; btn = 1'b1;
    repeat (3) @(negedge clk);
    check("seq_stateC", state_out, 2);
    check("seq_busyC", busy, 1);
    check("seq_noload_C", load_en, 0);
    @(negedge clk);
    check("seq_load", load_en, 1);
    check("seq_data", result_data, 8);
    check("seq_stateD", state_out, 3);
    check("seq_busyD", busy, 0);
    @(negedge clk);
    check("seq_load_drop", load_en, 0);
    btn = 1'b0;
    repeat (4) @(negedge clk);
    check("seq_loadcnt", load_cnt - base, 1);
    check("seq_hold", result_data, 8);

    // Table-driven arithmetic
    foreach (vecs[i]) begin
      do_reset();
      base = load_cnt;
      press(vecs[i].a, 1'b0);
      press(vecs[i].b, vecs[i].sub);
      check($sformatf("vec%0d_loads", i), load_cnt - base, 1);
      check($sformatf("vec%0d_strobe", i), load_res, vecs[i].exp);
      check($sformatf("vec%0d_held", i), result_data, vecs[i].exp);
      check($sformatf("vec%0d_state", i), state_out, 3);
    end

    // Press latency: first sample at edge N, acted on at N+2
    do_reset();
    sw = 4'd6; btn = 1'b1;
    @(negedge clk);
    check("lat_N", state_out, 0);
    @(negedge clk);
    check("lat_N1", state_out, 0);
    @(negedge clk);
    check("lat_N2", state_out, 1);

    // Held high 50 cycles: one capture only
    repeat (50) @(negedge clk);
    check("hold_state", state_out, 1);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    base = load_cnt;
    press(4'd1, 1'b0);
    check("hold_loads", load_cnt - base, 1);
    check("hold_result", load_res, 7);

    // Rapid re-press right after the operand-B press: single load only
    do_reset();
    press(4'd4, 1'b0);
    base = load_cnt;
    sw = 4'd2; op_sub = 1'b0; btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    @(negedge clk); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    repeat (6) @(negedge clk);
    check("rapid_loads", load_cnt - base, 1);
    check("rapid_result", load_res, 6);
`ifdef CALC_CHAIN_EN
    check("rapid_state", state_out, 1);
`else
    check("rapid_state", state_out, 0);
`endif

    // Reset on the edge that would enter COMPUTE
    do_reset();
    press(4'd9, 1'b0);
    press(4'd4, 1'b0);
    check("rst_pre_result", result_data, 13);
    press(4'd0, 1'b0);
`ifndef CALC_CHAIN_EN
    press(4'd5, 1'b0);
`endif
    check("rst_pre_state", state_out, 1);
    base = load_cnt;
    sw = 4'd3; btn = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; btn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_state", state_out, 0);
    check("rst_result", result_data, 0);
    @(negedge clk);
    check("rst_noload", load_en, 0);
    repeat (4) @(negedge clk);
    check("rst_loadcnt", load_cnt - base, 0);
    check("rst_state_after", state_out, 0);

    // DONE-state press behaviour
    do_reset();
    press(4'd9, 1'b0);
    press(4'd8, 1'b0);
    check("done_result", result_data, 17);
    press(4'd15, 1'b1);
`ifdef CALC_CHAIN_EN
    check("chain_state", state_out, 1);
    base = load_cnt;
    press(4'd2, 1'b0);
    check("chain_loads", load_cnt - base, 1);
    check("chain_result", load_res, 3);
`else
    check("done_state", state_out, 0);
    check("done_hold", result_data, 17);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
